// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct constants, control bundle and
// the decoded-entry payload carried through the decode stage.
package decode_stage_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned REG_AW = 5;
    // PC field width inside the decoded entry; decode_stage XLEN must not exceed it
    localparam int unsigned PC_W   = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_BR_ILL_A = 3'b010;
    localparam logic [2:0] F3_BR_ILL_B = 3'b011;
    localparam logic [2:0] F3_LD_ILL_A = 3'b011;
    localparam logic [2:0] F3_LD_ILL_B = 3'b110;
    localparam logic [2:0] F3_LD_ILL_C = 3'b111;
    localparam logic [2:0] F3_ST_MAX   = 3'b010;

    typedef enum logic [4:0] {
        EXE_ADD_OP, EXE_SUB_OP, EXE_SLL_OP, EXE_SLT_OP, EXE_SLTU_OP,
        EXE_XOR_OP, EXE_SRL_OP, EXE_SRA_OP, EXE_OR_OP, EXE_AND_OP,
        EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP,
        EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP
    } alu_op_t;

    typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} srca_t;
    typedef enum logic {SRCB_RS2, SRCB_IMM} srcb_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
    typedef enum logic [3:0] {
        BJ_NOOP, BJ_JAL, BJ_JALR, BJ_BEQ, BJ_BNE, BJ_BLT, BJ_BGE, BJ_BLTU, BJ_BGEU
    } bj_op_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    typedef struct packed {
        alu_op_t    alu_op;
        srca_t      srca;
        srcb_t      srcb;
        imm_sel_t   imm_sel;
        bj_op_t     bj_op;
        wb_sel_t    wb_sel;
        logic       reg_we;
        logic       mem_re;
        logic       mem_d_we;
        logic [2:0] mem_size;
    } controlsgs_t;

    typedef struct packed {
        controlsgs_t       ctrl;
        logic [PC_W-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              illegal;
    } dec_entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stage_state_t;

    // funct3 -> ALU op for the non-alternate integer ops
    function automatic alu_op_t base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = EXE_ADD_OP;
            3'b001:  base_alu = EXE_SLL_OP;
            3'b010:  base_alu = EXE_SLT_OP;
            3'b011:  base_alu = EXE_SLTU_OP;
            3'b100:  base_alu = EXE_XOR_OP;
            3'b101:  base_alu = EXE_SRL_OP;
            3'b110:  base_alu = EXE_OR_OP;
            default: base_alu = EXE_AND_OP;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_logic.sv
// Combinational RV32I(+M) decoder: instruction word in, decoded entry out.
// The pc field is left zero; the stage fills it in.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [ILEN-1:0] i_instr,
    output dec_entry_t      o_entry
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    controlsgs_t w_ctrl;
    logic        w_ill;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_rd     = i_instr[11:7];

    always_comb begin
        w_ctrl = '0;
        w_ill  = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_ctrl.srca = SRCA_ZERO;  w_ctrl.srcb = SRCB_IMM;
                w_ctrl.imm_sel = IMM_U;   w_ctrl.reg_we = 1'b1;
            end
            OP_AUIPC: begin
                w_ctrl.srca = SRCA_PC;    w_ctrl.srcb = SRCB_IMM;
                w_ctrl.imm_sel = IMM_U;   w_ctrl.reg_we = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.srca = SRCA_PC;    w_ctrl.srcb = SRCB_IMM;
                w_ctrl.imm_sel = IMM_J;   w_ctrl.bj_op = BJ_JAL;
                w_ctrl.wb_sel = WB_PC4;   w_ctrl.reg_we = 1'b1;
            end
            OP_JALR: begin
                w_ctrl.srcb = SRCB_IMM;   w_ctrl.imm_sel = IMM_I;
                w_ctrl.bj_op = BJ_JALR;   w_ctrl.wb_sel = WB_PC4;
                w_ctrl.reg_we = 1'b1;
            end
            OP_BRANCH: begin
                w_ctrl.srca = SRCA_PC;    w_ctrl.srcb = SRCB_IMM;
                w_ctrl.imm_sel = IMM_B;
                case (w_f3)
                    3'b000:  w_ctrl.bj_op = BJ_BEQ;
                    3'b001:  w_ctrl.bj_op = BJ_BNE;
                    3'b100:  w_ctrl.bj_op = BJ_BLT;
                    3'b101:  w_ctrl.bj_op = BJ_BGE;
                    3'b110:  w_ctrl.bj_op = BJ_BLTU;
                    3'b111:  w_ctrl.bj_op = BJ_BGEU;
                    default: w_ill = 1'b1;
                endcase
                if (w_f3 == F3_BR_ILL_A || w_f3 == F3_BR_ILL_B) w_ill = 1'b1;
            end
            OP_LOAD: begin
                w_ctrl.srcb = SRCB_IMM;   w_ctrl.imm_sel = IMM_I;
                w_ctrl.mem_re = 1'b1;     w_ctrl.wb_sel = WB_MEM;
                w_ctrl.reg_we = 1'b1;     w_ctrl.mem_size = w_f3;
                if (w_f3 == F3_LD_ILL_A || w_f3 == F3_LD_ILL_B || w_f3 == F3_LD_ILL_C)
                    w_ill = 1'b1;
            end
            OP_STORE: begin
                w_ctrl.srcb = SRCB_IMM;   w_ctrl.imm_sel = IMM_S;
                w_ctrl.mem_d_we = 1'b1;   w_ctrl.mem_size = w_f3;
                if (w_f3 > F3_ST_MAX) w_ill = 1'b1;
            end
            OP_IMM: begin
                w_ctrl.srcb = SRCB_IMM;   w_ctrl.imm_sel = IMM_I;
                w_ctrl.reg_we = 1'b1;     w_ctrl.alu_op = base_alu(w_f3);
                if (w_f3 == F3_SLL && w_f7 != FUNCT7_BASE) w_ill = 1'b1;
                if (w_f3 == F3_SR) begin
                    if (w_f7 == FUNCT7_ALT)       w_ctrl.alu_op = EXE_SRA_OP;
                    else if (w_f7 != FUNCT7_BASE) w_ill = 1'b1;
                end
            end
            OP_OP: begin
                w_ctrl.reg_we = 1'b1;
                case (w_f7)
                    FUNCT7_BASE: w_ctrl.alu_op = base_alu(w_f3);
                    FUNCT7_ALT: begin
                        if (w_f3 == F3_ADD)     w_ctrl.alu_op = EXE_SUB_OP;
                        else if (w_f3 == F3_SR) w_ctrl.alu_op = EXE_SRA_OP;
                        else                    w_ill = 1'b1;
                    end
                    FUNCT7_MULDIV: begin
                        // M ops are laid out in funct3 order starting at MUL
                        if (EN_M) w_ctrl.alu_op = alu_op_t'(5'(EXE_MUL_OP) + 5'(w_f3));
                        else      w_ill = 1'b1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_FENCE: ;
            default: w_ill = 1'b1;
        endcase
        if (w_ill)       w_ctrl = '0;
        if (w_rd == '0)  w_ctrl.reg_we = 1'b0;
    end

    always_comb begin
        o_entry         = '0;
        o_entry.ctrl    = w_ctrl;
        o_entry.rs1     = i_instr[19:15];
        o_entry.rs2     = i_instr[24:20];
        o_entry.rd      = w_rd;
        o_entry.illegal = w_ill;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main + skid slot holding decoded entries, valid/ready
// on both sides with a registered in_ready, and a saturating illegal counter.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter bit          EN_M  = 1'b0,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output controlsgs_t       out_ctrl,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    stage_state_t     r_state, w_state_nxt;
    logic             r_out_valid, r_in_ready;
    dec_entry_t       r_main, r_skid, w_dec, w_entry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_xfer, w_out_xfer;
    logic             w_load_main, w_load_skid, w_skid_to_main;

    decode_logic #(.EN_M(EN_M)) u_decode_logic (
        .i_instr (in_instr),
        .o_entry (w_dec)
    );

    always_comb begin
        w_entry    = w_dec;
        w_entry.pc = PC_W'(in_pc);
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_SKID);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_FULL;
                ST_FULL: begin
                    if (w_out_xfer && !w_in_xfer)      w_state_nxt = ST_EMPTY;
                    else if (!w_out_xfer && w_in_xfer) w_state_nxt = ST_SKID;
                end
                ST_SKID:  if (w_out_xfer) w_state_nxt = ST_FULL;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot-load strobes; a flush suppresses every load
    always_comb begin
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_load_main = w_in_xfer;
                ST_FULL: begin
                    w_load_main = w_in_xfer && w_out_xfer;
                    w_load_skid = w_in_xfer && !w_out_xfer;
                end
                ST_SKID:  w_skid_to_main = w_out_xfer;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main)         r_main <= w_entry;
            else if (w_skid_to_main) r_main <= r_skid;
            if (w_load_skid)         r_skid <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_in_xfer && !flush && w_entry.illegal && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_ctrl      = r_main.ctrl;
    assign out_pc        = XLEN'(r_main.pc);
    assign out_rs1       = r_main.rs1;
    assign out_rs2       = r_main.rs2;
    assign out_rd        = r_main.rd;
    assign out_illegal   = r_main.illegal;
    assign illegal_count = r_cnt;

endmodule
